sad_accum_int16: RTL and testbench

Sequential sum-of-absolute-differences (SAD) accumulator. It sits directly downstream of the 16-bit integer subtractor (`subtractor_nbit`). The block consumes a stream of signed two's-complement differences over a valid/ready handshake and accumulates their absolute values over a programmed block length. It presents one result per block on an output handshake, turning the combinational subtraction benchmark into a streaming vector-distance kernel for PIM synthesis studies.

---
 rtl/sad_pkg.sv | 21 ++
 rtl/sad_accum_int16_if.sv | 28 ++
 rtl/abs_unit_nbit.sv | 20 ++
 rtl/sad_accum_int16.sv | 112 +++++++++++
 tb/tb_sad_accum_int16.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// Shared types and helpers for the SAD accumulator: FSM state encoding and
// the signed-to-magnitude function used by abs_unit_nbit.
package sad_pkg;

  localparam int SAD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sad_state_e;

  // Magnitude of a two's-complement value; the most negative input maps to
  // 2^(SAD_WIDTH-1), which still fits because the result is unsigned.
  function automatic logic [SAD_WIDTH-1:0] sad_abs(input logic signed [SAD_WIDTH-1:0] x);
    logic [SAD_WIDTH-1:0] u;
    u = x;
    return u[SAD_WIDTH-1] ? (~u + SAD_WIDTH'(1)) : u;
  endfunction

endpackage

// File: rtl/sad_accum_int16_if.sv
// Stream-in / result-out bundle of sad_accum_int16. Handshakes: a transfer
// happens on a rising edge where valid && ready; valid never waits on ready.
interface sad_accum_int16_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic [CNT_WIDTH-1:0] len;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_diff;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sad;
  logic                 out_sat;
  logic                 busy;

  modport master (
    output start, len, in_valid, in_diff, out_ready,
    input  in_ready, out_valid, out_sad, out_sat, busy
  );

  modport slave (
    input  start, len, in_valid, in_diff, out_ready,
    output in_ready, out_valid, out_sad, out_sat, busy
  );
endinterface

// File: rtl/abs_unit_nbit.sv
// Purely combinational |x| of a signed WIDTH-bit difference, kept as its own
// synthesis target next to the subtractor.
module abs_unit_nbit
  import sad_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] diff_i,
  output logic [WIDTH-1:0] abs_o
);

  generate
    if (WIDTH == SAD_WIDTH) begin : g_pkg
      assign abs_o = sad_abs(diff_i);
    end else begin : g_generic
      assign abs_o = diff_i[WIDTH-1] ? (~diff_i + WIDTH'(1)) : diff_i;
    end
  endgenerate

endmodule

// File: rtl/sad_accum_int16.sv
// Streaming sum-of-absolute-differences accumulator over a programmed block.
// Build option SAD_SATURATE_EN: clamp the accumulator and flag out_sat.
module sad_accum_int16
  import sad_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sad_accum_int16_if.slave       bus,
  output sad_state_e             dbg_state
);

  sad_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]     abs_val;
  logic [ACC_WIDTH-1:0] abs_ext;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 accept;

  abs_unit_nbit #(.WIDTH(WIDTH)) u_abs (
    .diff_i (bus.in_diff),
    .abs_o  (abs_val)
  );

  assign abs_ext = ACC_WIDTH'(abs_val);
  assign accept  = (state_q == RUN) && bus.in_valid;

`ifdef SAD_SATURATE_EN
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 clamp;

  assign sum_wide = {1'b0, acc_q} + {1'b0, abs_ext};
  assign clamp    = sum_wide[ACC_WIDTH];
  assign acc_next = clamp ? '1 : sum_wide[ACC_WIDTH-1:0];
`else
  assign acc_next = acc_q + abs_ext;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
`ifdef SAD_SATURATE_EN
    sat_d   = sat_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
`ifdef SAD_SATURATE_EN
          sat_d = 1'b0;
`endif
          if (bus.len != '0) begin
            rem_d   = bus.len;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (accept) begin
          acc_d = acc_next;
          rem_d = rem_q - CNT_WIDTH'(1);
`ifdef SAD_SATURATE_EN
          if (clamp) sat_d = 1'b1;
`endif
          if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here, even on the handshake cycle
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

`ifdef SAD_SATURATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
  assign bus.out_sat = sat_q;
`else
  assign bus.out_sat = 1'b0;
`endif

  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_sad   = acc_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sad_accum_int16.sv
// Directed bench for sad_accum_int16: scoreboard on the 32-bit instance plus
// a 16-bit-accumulator instance for the overflow/saturation corner.
module tb_sad_accum_int16;
  import sad_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [32:0] exp_q[$];

  sad_accum_int16_if #(.WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) bus_a ();
  sad_accum_int16_if #(.WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) bus_b ();
  sad_state_e st_a;
  sad_state_e st_b;

  sad_accum_int16 #(.WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .dbg_state (st_a)
  );

  sad_accum_int16 #(.WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .dbg_state (st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: compare every accepted result against the queue
  always @(negedge clk) begin
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got sat=%0d sad=%0d with empty queue",
                 bus_a.out_sat, bus_a.out_sad);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({bus_a.out_sat, bus_a.out_sad} !== e) begin
          n_err++;
          $display("FAIL result: got sat=%0d sad=%0d expected sat=%0d sad=%0d",
                   bus_a.out_sat, bus_a.out_sad, e[32], e[31:0]);
        end
      end
    end
  end

  // driver tasks: all enter and leave 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (st_a != IDLE && n < 100) begin
      tick();
      n++;
    end
    if (st_a != IDLE) check("idle_timeout", 64'(st_a), 64'(IDLE));
  endtask

  task automatic start_block(input logic [7:0] l);
    bus_a.start = 1'b1;
    bus_a.len   = l;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic send_diff(input logic [15:0] d);
    logic ok;
    int   n;
    bus_a.in_valid = 1'b1;
    bus_a.in_diff  = d;
    n = 0;
    do begin
      ok = bus_a.in_ready;
      tick();
      n++;
    end while (!ok && n < 100);
    if (!ok) check("in_ready_timeout", 64'(ok), 64'd1);
    bus_a.in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_b_sad;
    logic        exp_b_sat;
    int          n;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.len = '0; bus_a.in_valid = 1'b0; bus_a.in_diff = '0;
    bus_a.out_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.len = '0; bus_b.in_valid = 1'b0; bus_b.in_diff = '0;
    bus_b.out_ready = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_in_ready",  64'(bus_a.in_ready),  64'd0);
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_out_sad",   64'(bus_a.out_sad),   64'd0);
    check("rst_out_sat",   64'(bus_a.out_sat),   64'd0);
    check("rst_busy",      64'(bus_a.busy),      64'd0);
    check("rst_state",     64'(st_a),            64'(IDLE));
    rst_n = 1'b1;
    tick();

    // basic block: 5 + 3 + 0 + 7
    exp_q.push_back({1'b0, 32'd15});
    start_block(8'd4);
    check("basic_busy", 64'(bus_a.busy), 64'd1);
    send_diff(16'd5);
    send_diff(16'hFFFD);
    send_diff(16'd0);
    send_diff(16'hFFF9);
    check("basic_latency_valid", 64'(bus_a.out_valid), 64'd1);
    wait_idle();

    // most negative difference
    exp_q.push_back({1'b0, 32'd32768});
    start_block(8'd1);
    send_diff(16'h8000);
    check("corner_valid", 64'(bus_a.out_valid), 64'd1);
    wait_idle();

    // zero length, result held under back-pressure
    bus_a.out_ready = 1'b0;
    start_block(8'd0);
    check("zero_valid",    64'(bus_a.out_valid), 64'd1);
    check("zero_sad",      64'(bus_a.out_sad),   64'd0);
    check("zero_in_ready", 64'(bus_a.in_ready),  64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("zero_hold_valid", 64'(bus_a.out_valid), 64'd1);
      check("zero_hold_sad",   64'(bus_a.out_sad),   64'd0);
      check("zero_hold_ready", 64'(bus_a.in_ready),  64'd0);
    end
    exp_q.push_back({1'b0, 32'd0});
    bus_a.out_ready = 1'b1;
    tick();
    wait_idle();

    // bubbles and ignored starts: 2 + 4 + 6
    exp_q.push_back({1'b0, 32'd12});
    start_block(8'd3);
    bus_a.in_valid = 1'b1; bus_a.in_diff = 16'd2; tick();
    bus_a.in_valid = 1'b0; bus_a.start = 1'b1; bus_a.len = 8'd9; tick();
    bus_a.start = 1'b0;
    check("run_start_ignored", 64'(st_a), 64'(RUN));
    tick();
    bus_a.in_valid = 1'b1; bus_a.in_diff = 16'hFFFC; tick();
    bus_a.in_valid = 1'b0; tick();
    check("bubble_still_run", 64'(st_a), 64'(RUN));
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_diff = 16'd6; tick();
    bus_a.in_valid = 1'b0;
    check("bubble_done", 64'(st_a), 64'(DONE));
    bus_a.start = 1'b1; bus_a.len = 8'd5; tick();
    check("done_start_ignored", 64'(st_a), 64'(DONE));
    check("done_sad_stable", 64'(bus_a.out_sad), 64'd12);
    bus_a.out_ready = 1'b1; tick();
    check("handshake_start_ignored", 64'(st_a), 64'(IDLE));
    bus_a.start = 1'b0;
    tick();
    check("no_late_start", 64'(bus_a.busy), 64'd0);

    // reset in the middle of a block
    start_block(8'd4);
    send_diff(16'd3);
    send_diff(16'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state",     64'(st_a),            64'(IDLE));
    check("mid_rst_in_ready",  64'(bus_a.in_ready),  64'd0);
    check("mid_rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("mid_rst_out_sad",   64'(bus_a.out_sad),   64'd0);
    check("mid_rst_busy",      64'(bus_a.busy),      64'd0);
    #2;
    rst_n = 1'b1;
    tick();
    exp_q.push_back({1'b0, 32'd2});
    start_block(8'd2);
    send_diff(16'd1);
    send_diff(16'd1);
    wait_idle();

    // 16-bit accumulator overflow: three times 32768
`ifdef SAD_SATURATE_EN
    exp_b_sad = 16'hFFFF;
    exp_b_sat = 1'b1;
`else
    exp_b_sad = 16'h8000;
    exp_b_sat = 1'b0;
`endif
    bus_b.start = 1'b1; bus_b.len = 8'd3; tick();
    bus_b.start = 1'b0;
    bus_b.in_valid = 1'b1; bus_b.in_diff = 16'h8000;
    repeat (3) tick();
    bus_b.in_valid = 1'b0;
    check("ovf_valid", 64'(bus_b.out_valid), 64'd1);
    check("ovf_sad",   64'(bus_b.out_sad),   64'(exp_b_sad));
    check("ovf_sat",   64'(bus_b.out_sat),   64'(exp_b_sat));
    bus_b.out_ready = 1'b1; tick();
    check("ovf_idle", 64'(st_b), 64'(IDLE));

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
